gyruss_hiscore_ctrl: RTL and testbench
======================================

Name: gyruss_hiscore_ctrl

Overview:
- Sequencer directly upstream of the Gyruss core's high-score port (hs_address, hs_data_in, hs_write, hs_access; reads return on hs_data_out).
- Load path: accepts MiSTer download bytes into a 2-entry FIFO and writes them into core RAM.
- Dump path: reads a fixed-length high-score region and streams it out over a valid/ready handshake.
- All core accesses happen only while the core is paused. The block raises pause_req and waits for paused before touching RAM.

Parameters:
- HS_LEN, 128: number of bytes in the high-score region; dump reads addresses 0..HS_LEN-1.
- RD_LAT, 2: cycles from hs_address presented to hs_data_out valid.
- BASE, 11'h000: address offset added to every hs_address.

Ports:
- clk_49m  in  1  system clock, 49.152 MHz
- reset  in  1  asynchronous, active-high
- paused  in  1  core has stopped; RAM is safe to access
- pause_req  out  1  request core pause; OR'd into the core pause input
- dl_wr  in  1  download byte strobe, one cycle
- dl_addr  in  11  download byte offset
- dl_data  in  8  download byte
- dl_busy  out  1  FIFO full; dl_wr is dropped while high
- dump_start  in  1  pulse; begin dump
- ul_data  out  8  dump byte
- ul_valid  out  1  ul_data valid
- ul_ready  in  1  consumer accepts byte when ul_valid and ul_ready are both high
- ul_done  out  1  one-cycle pulse after last byte accepted
- hs_address  out  11  to core
- hs_data_in  out  8  to core
- hs_write  out  1  to core
- hs_access  out  1  to core
- hs_data_out  in  8  from core

Behaviour:
- Reset values: all outputs 0; FIFO empty; state IDLE.
- FIFO: 2 entries of {addr, data}.
  - Push on dl_wr while not full.
  - dl_busy = full.
  - Push and pop in the same cycle with the FIFO full is allowed; the count stays 2.
- pause_req = FIFO non-empty, or state not in {IDLE, DONE}.
- States:
  - IDLE
    - If FIFO non-empty, go to WAIT_W.
    - Else if dump_start, clear cnt to 0 and go to WAIT_R.
    - Load has priority when both are pending.
    - A dump_start arriving in any other state is latched as dump_pend and serviced on the next return to IDLE.
  - WAIT_W: when paused=1, go to WR.
  - WR: one cycle.
    - hs_access=1, hs_write=1, hs_address=BASE+fifo_addr, hs_data_in=fifo_data; pop.
    - Next state: WR again if FIFO still non-empty and paused=1; else IDLE.
    - Back-to-back writes give 1 byte per cycle.
  - WAIT_R: when paused=1, go to RD.
  - RD: hold hs_access=1 and hs_address=BASE+cnt for RD_LAT cycles (latency counter), then capture hs_data_out into ul_data and go to OUT.
  - OUT: ul_valid=1 and hs_access=0.
    - On handshake: cnt+1, ul_valid=0.
    - If cnt was HS_LEN-1, go to DONE; else go to WAIT_R.
    - ul_data stays stable while ul_valid=1 and ul_ready=0.
  - DONE: ul_done=1 for one cycle, then IDLE.
- cnt is 11 bits. HS_LEN must be ≤ 2048-BASE, so BASE+cnt never wraps.
- paused dropping mid-operation:
  - WR: the current write completes, the remaining entries wait in WAIT_W.
  - RD: abort the current read, return to WAIT_R and restart the same address; cnt is unchanged.
- hs_write only ever asserts together with hs_access.
- hs_access is low in IDLE, WAIT_*, OUT and DONE.
- Asynchronous reset mid-operation returns to reset values immediately; there is no partial output after reset.

Optional Feature:
- Macro: HS_CHECKSUM_EN.
- Defined:
  - The block keeps an 8-bit running sum of the dumped bytes.
  - After byte HS_LEN-1 is accepted, OUT presents one extra byte, (~sum+1) mod 256, with ul_valid, then goes to DONE.
  - Total bytes per dump: HS_LEN+1.
  - The sum is cleared at dump start.
- Undefined: exactly HS_LEN bytes and no sum register.

Test Plan:
- Reset with dl_wr/dump_start idle -> all outputs 0, pause_req=0.
- dl_wr addr=5 data=8'hA7, paused tied high after 3 cycles -> pause_req high the next cycle; a single WR cycle with hs_address=BASE+5, hs_data_in=A7, hs_write=1; pause_req falls.
- Three dl_wr on consecutive cycles with paused=0 -> third write dropped, dl_busy=1 after the second; raise paused -> two consecutive WR cycles, in order.
- Model RAM byte[i]=i^8'h5A with RD_LAT=2, dump_start, ul_ready random -> 128 bytes 5A,5B,58,... in order, stable under backpressure, ul_done once.
- Drop paused during RD of address 10 -> hs_access falls; on re-pause, address 10 is re-read; the output stream has no gaps or duplicates.
- HS_CHECKSUM_EN with all bytes 8'h01 -> 129th byte is 8'h80 (128 mod 256 = 0x80, negated = 0x80); without the macro, exactly 128 bytes.

Source files
------------

// File: rtl/gyruss_hiscore_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : gyruss_hiscore_ctrl_if
//  Purpose  : Bundles the Gyruss core high-score RAM port.
//             master = sequencer side, slave = core side.
//  Signals  : hs_address  [10:0]  byte address into core RAM
//             hs_data_in  [7:0]   write data to core
//             hs_write            write strobe (only with hs_access)
//             hs_access           core RAM access enable
//             hs_data_out [7:0]   read data from core
//  Revision : 1.0  initial release
// ============================================================================
interface gyruss_hiscore_ctrl_if;
    logic [10:0] hs_address;
    logic [7:0]  hs_data_in;
    logic        hs_write;
    logic        hs_access;
    logic [7:0]  hs_data_out;

    modport master (
        output hs_address,
        output hs_data_in,
        output hs_write,
        output hs_access,
        input  hs_data_out
    );

    modport slave (
        input  hs_address,
        input  hs_data_in,
        input  hs_write,
        input  hs_access,
        output hs_data_out
    );
endinterface
`default_nettype wire

// File: rtl/gyruss_hiscore_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : gyruss_hiscore_ctrl
//  Purpose  : High-score load/dump sequencer in front of the Gyruss core RAM.
//             Load : download bytes -> 2-entry FIFO -> core RAM writes.
//             Dump : reads HS_LEN bytes from BASE and streams them out over a
//                    valid/ready handshake, pulsing ul_done at the end.
//             Core RAM is only touched while the core reports paused.
//  Ports    : clk_49m, reset (async, active-high)
//             paused / pause_req          core pause handshake
//             dl_wr, dl_addr, dl_data     download byte input, dl_busy = full
//             dump_start                  pulse, starts a dump
//             ul_data, ul_valid, ul_ready stream out, ul_done end pulse
//             hs (master modport)         core high-score RAM port
//  Macro    : HS_CHECKSUM_EN - appends one two's-complement checksum byte
//             (~sum+1) to every dump.
//  Read timing: the address is held while a latency counter runs from 0 to
//             RD_LAT; hs_data_out is captured on the edge that ends the
//             cycle in which the counter equals RD_LAT, i.e. data is expected
//             to be stable RD_LAT cycles after the address is presented.
//  Revision : 1.0  initial release
// ============================================================================
module gyruss_hiscore_ctrl #(
    parameter int          HS_LEN = 128,
    parameter int          RD_LAT = 2,
    parameter logic [10:0] BASE   = 11'h000
) (
    input  wire logic        clk_49m,
    input  wire logic        reset,
    input  wire logic        paused,
    output      logic        pause_req,
    input  wire logic        dl_wr,
    input  wire logic [10:0] dl_addr,
    input  wire logic [7:0]  dl_data,
    output      logic        dl_busy,
    input  wire logic        dump_start,
    output      logic [7:0]  ul_data,
    output      logic        ul_valid,
    input  wire logic        ul_ready,
    output      logic        ul_done,
    gyruss_hiscore_ctrl_if.master hs
);

    localparam int          c_LAT_W = $clog2(RD_LAT + 1) + 1;
    localparam logic [10:0] c_LAST  = 11'(HS_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT_W = 3'd1,
        S_WR     = 3'd2,
        S_WAIT_R = 3'd3,
        S_RD     = 3'd4,
        S_OUT    = 3'd5,
        S_CK     = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    state_t               r_state;

    // ------------------------------------------------------------------
    // Download FIFO (2 entries of {addr, data})
    // ------------------------------------------------------------------
    logic [10:0]          r_fifo_addr [0:1];
    logic [7:0]           r_fifo_data [0:1];
    logic                 r_wptr;
    logic                 r_rptr;
    logic [1:0]           r_count;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_pop;
    logic                 w_push;
    logic [10:0]          w_head_addr;
    logic [7:0]           w_head_data;

    assign w_full      = (r_count == 2'd2);
    assign w_empty     = (r_count == 2'd0);
    assign w_head_addr = r_fifo_addr[r_rptr];
    assign w_head_data = r_fifo_data[r_rptr];

    // The pop is the same edge that loads the head entry into the write
    // registers, so WR always shows an entry already removed from the FIFO.
    assign w_pop  = paused && !w_empty &&
                    ((r_state == S_WAIT_W) || (r_state == S_WR));
    // A full FIFO still accepts a byte on a popping edge: the write pointer
    // equals the read pointer, and the popped value is read before the
    // slot is overwritten.
    assign w_push = dl_wr && (!w_full || w_pop);

    always_ff @(posedge clk_49m) begin
        if (w_push) begin
            r_fifo_addr[r_wptr] <= dl_addr;
            r_fifo_data[r_wptr] <= dl_data;
        end
    end

    always_ff @(posedge clk_49m or posedge reset) begin
        if (reset) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) r_wptr <= ~r_wptr;
            if (w_pop)  r_rptr <= ~r_rptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign dl_busy   = w_full;
    assign pause_req = !w_empty || !((r_state == S_IDLE) || (r_state == S_DONE));

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    logic [10:0]          r_cnt;
    logic [c_LAT_W-1:0]   r_lat;
    logic                 r_dump_pend;
    logic [10:0]          r_hs_address;
    logic [7:0]           r_hs_data_in;
    logic                 r_hs_write;
    logic                 r_hs_access;
    logic [7:0]           r_ul_data;
    logic                 r_ul_valid;
    logic                 r_ul_done;
`ifdef HS_CHECKSUM_EN
    logic [7:0]           r_sum;
`endif

    always_ff @(posedge clk_49m or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= 11'd0;
            r_lat        <= '0;
            r_dump_pend  <= 1'b0;
            r_hs_address <= 11'd0;
            r_hs_data_in <= 8'd0;
            r_hs_write   <= 1'b0;
            r_hs_access  <= 1'b0;
            r_ul_data    <= 8'd0;
            r_ul_valid   <= 1'b0;
            r_ul_done    <= 1'b0;
`ifdef HS_CHECKSUM_EN
            r_sum        <= 8'd0;
`endif
        end else begin
            r_ul_done <= 1'b0;
            // Any dump request is remembered; the IDLE branch that starts a
            // dump clears it again (later assignment wins).
            if (dump_start) r_dump_pend <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_state <= S_WAIT_W;
                    end else if (dump_start || r_dump_pend) begin
                        r_cnt       <= 11'd0;
                        r_dump_pend <= 1'b0;
`ifdef HS_CHECKSUM_EN
                        r_sum       <= 8'd0;
`endif
                        r_state     <= S_WAIT_R;
                    end
                end

                S_WAIT_W: begin
                    if (w_pop) begin
                        r_hs_access  <= 1'b1;
                        r_hs_write   <= 1'b1;
                        r_hs_address <= BASE + w_head_addr;
                        r_hs_data_in <= w_head_data;
                        r_state      <= S_WR;
                    end
                end

                S_WR: begin
                    if (w_pop) begin
                        r_hs_address <= BASE + w_head_addr;
                        r_hs_data_in <= w_head_data;
                    end else begin
                        // Lost pause or FIFO drained: remaining entries are
                        // picked up again from IDLE via WAIT_W.
                        r_hs_access  <= 1'b0;
                        r_hs_write   <= 1'b0;
                        r_hs_address <= 11'd0;
                        r_hs_data_in <= 8'd0;
                        r_state      <= S_IDLE;
                    end
                end

                S_WAIT_R: begin
                    if (paused) begin
                        r_hs_access  <= 1'b1;
                        r_hs_address <= BASE + r_cnt;
                        r_lat        <= '0;
                        r_state      <= S_RD;
                    end
                end

                S_RD: begin
                    if (!paused) begin
                        // Abort; the same address is retried from WAIT_R.
                        r_hs_access  <= 1'b0;
                        r_hs_address <= 11'd0;
                        r_state      <= S_WAIT_R;
                    end else if (r_lat == c_LAT_W'(RD_LAT)) begin
                        r_ul_data    <= hs.hs_data_out;
                        r_ul_valid   <= 1'b1;
                        r_hs_access  <= 1'b0;
                        r_hs_address <= 11'd0;
                        r_state      <= S_OUT;
                    end else begin
                        r_lat <= r_lat + c_LAT_W'(1);
                    end
                end

                S_OUT: begin
                    if (ul_ready) begin
                        r_ul_valid <= 1'b0;
                        r_cnt      <= r_cnt + 11'd1;
`ifdef HS_CHECKSUM_EN
                        r_sum      <= r_sum + r_ul_data;
`endif
                        if (r_cnt == c_LAST) begin
`ifdef HS_CHECKSUM_EN
                            // Two's-complement of the full byte sum so that
                            // all HS_LEN+1 bytes add up to zero.
                            r_ul_data  <= ~(r_sum + r_ul_data) + 8'd1;
                            r_ul_valid <= 1'b1;
                            r_state    <= S_CK;
`else
                            r_ul_done  <= 1'b1;
                            r_state    <= S_DONE;
`endif
                        end else begin
                            r_state <= S_WAIT_R;
                        end
                    end
                end

                S_CK: begin
                    if (ul_ready) begin
                        r_ul_valid <= 1'b0;
                        r_ul_done  <= 1'b1;
                        r_state    <= S_DONE;
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ul_data          = r_ul_data;
    assign ul_valid         = r_ul_valid;
    assign ul_done          = r_ul_done;
    assign hs.hs_address    = r_hs_address;
    assign hs.hs_data_in    = r_hs_data_in;
    assign hs.hs_write      = r_hs_write;
    assign hs.hs_access     = r_hs_access;

endmodule
`default_nettype wire

// File: tb/tb_gyruss_hiscore_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_gyruss_hiscore_ctrl
//  Purpose  : Directed self-checking bench for gyruss_hiscore_ctrl with a
//             two-stage registered core RAM model (RD_LAT = 2).
//  Revision : 1.0  initial release
// ============================================================================
module tb_gyruss_hiscore_ctrl;

    localparam int          HS_LEN = 128;
    localparam logic [10:0] BASE   = 11'h000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        paused = 1'b0;
    logic        dl_wr = 1'b0;
    logic [10:0] dl_addr = 11'd0;
    logic [7:0]  dl_data = 8'd0;
    logic        dump_start = 1'b0;
    logic        ul_ready = 1'b0;
    logic        pause_req;
    logic        dl_busy;
    logic [7:0]  ul_data;
    logic        ul_valid;
    logic        ul_done;

    int n_checks = 0;
    int n_pass   = 0;

    gyruss_hiscore_ctrl_if hs_bus ();

    gyruss_hiscore_ctrl #(
        .HS_LEN (HS_LEN),
        .RD_LAT (2),
        .BASE   (BASE)
    ) dut (
        .clk_49m    (clk),
        .reset      (rst),
        .paused     (paused),
        .pause_req  (pause_req),
        .dl_wr      (dl_wr),
        .dl_addr    (dl_addr),
        .dl_data    (dl_data),
        .dl_busy    (dl_busy),
        .dump_start (dump_start),
        .ul_data    (ul_data),
        .ul_valid   (ul_valid),
        .ul_ready   (ul_ready),
        .ul_done    (ul_done),
        .hs         (hs_bus)
    );

    always #5 clk = ~clk;

    // Core RAM model: address registered twice before reaching hs_data_out.
    logic [7:0] mem [0:2047];
    logic [7:0] m_p1 = 8'd0;
    logic [7:0] m_p2 = 8'd0;
    int         n_writes = 0;
    int         n_bad_write = 0;
    assign hs_bus.hs_data_out = m_p2;

    always @(posedge clk) begin
        m_p1 <= mem[hs_bus.hs_address];
        m_p2 <= m_p1;
        if (hs_bus.hs_access && hs_bus.hs_write) begin
            mem[hs_bus.hs_address] = hs_bus.hs_data_in;
            n_writes <= n_writes + 1;
        end
        if (hs_bus.hs_write && !hs_bus.hs_access) n_bad_write <= n_bad_write + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_mem(input bit ones);
        for (int i = 0; i < 2048; i++) mem[i] = ones ? 8'h01 : (8'(i) ^ 8'h5A);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_checks++; if (pause_req !== 1'b0) $display("FAIL rst_pause_req_in_reset: got %b want 0", pause_req); else n_pass++;
        rst = 1'b0;
        tick();
        n_checks++; if (pause_req !== 1'b0) $display("FAIL rst_pause_req: got %b want 0", pause_req); else n_pass++;
        n_checks++; if (dl_busy !== 1'b0) $display("FAIL rst_dl_busy: got %b want 0", dl_busy); else n_pass++;
        n_checks++; if (ul_valid !== 1'b0) $display("FAIL rst_ul_valid: got %b want 0", ul_valid); else n_pass++;
        n_checks++; if (ul_done !== 1'b0) $display("FAIL rst_ul_done: got %b want 0", ul_done); else n_pass++;
        n_checks++; if (ul_data !== 8'h00) $display("FAIL rst_ul_data: got %h want 00", ul_data); else n_pass++;
        n_checks++; if (hs_bus.hs_access !== 1'b0) $display("FAIL rst_hs_access: got %b want 0", hs_bus.hs_access); else n_pass++;
        n_checks++; if (hs_bus.hs_write !== 1'b0) $display("FAIL rst_hs_write: got %b want 0", hs_bus.hs_write); else n_pass++;
        n_checks++; if (hs_bus.hs_address !== 11'h000) $display("FAIL rst_hs_address: got %h want 000", hs_bus.hs_address); else n_pass++;
        n_checks++; if (hs_bus.hs_data_in !== 8'h00) $display("FAIL rst_hs_data_in: got %h want 00", hs_bus.hs_data_in); else n_pass++;
    endtask

    task automatic test_single_write();
        bit found = 1'b0;
        paused  = 1'b0;
        dl_addr = 11'd5;
        dl_data = 8'hA7;
        dl_wr   = 1'b1;
        tick();
        dl_wr = 1'b0;
        n_checks++; if (pause_req !== 1'b1) $display("FAIL sw_pause_req_rise: got %b want 1", pause_req); else n_pass++;
        repeat (3) tick();
        n_checks++; if (hs_bus.hs_write !== 1'b0) $display("FAIL sw_no_write_unpaused: got %b want 0", hs_bus.hs_write); else n_pass++;
        paused = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (hs_bus.hs_write === 1'b1) found = 1'b1;
        end
        n_checks++; if (found !== 1'b1) $display("FAIL sw_write_seen: got %b want 1", found); else n_pass++;
        n_checks++; if (hs_bus.hs_address !== BASE + 11'd5) $display("FAIL sw_address: got %h want %h", hs_bus.hs_address, BASE + 11'd5); else n_pass++;
        n_checks++; if (hs_bus.hs_data_in !== 8'hA7) $display("FAIL sw_data: got %h want a7", hs_bus.hs_data_in); else n_pass++;
        n_checks++; if (hs_bus.hs_access !== 1'b1) $display("FAIL sw_access: got %b want 1", hs_bus.hs_access); else n_pass++;
        tick();
        n_checks++; if (hs_bus.hs_write !== 1'b0) $display("FAIL sw_single_cycle: got %b want 0", hs_bus.hs_write); else n_pass++;
        n_checks++; if (pause_req !== 1'b0) $display("FAIL sw_pause_req_fall: got %b want 0", pause_req); else n_pass++;
        n_checks++; if (mem[5] !== 8'hA7) $display("FAIL sw_ram_content: got %h want a7", mem[5]); else n_pass++;
        paused = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        int  w0;
        bit  found = 1'b0;
        paused = 1'b0;
        w0 = n_writes;
        dl_wr = 1'b1; dl_addr = 11'h010; dl_data = 8'h11;
        tick();
        n_checks++; if (dl_busy !== 1'b0) $display("FAIL b2b_busy_after_1: got %b want 0", dl_busy); else n_pass++;
        dl_addr = 11'h020; dl_data = 8'h22;
        tick();
        n_checks++; if (dl_busy !== 1'b1) $display("FAIL b2b_busy_after_2: got %b want 1", dl_busy); else n_pass++;
        dl_addr = 11'h030; dl_data = 8'h33;
        tick();
        dl_wr = 1'b0;
        n_checks++; if (dl_busy !== 1'b1) $display("FAIL b2b_busy_after_3: got %b want 1", dl_busy); else n_pass++;
        repeat (2) tick();
        n_checks++; if (n_writes !== w0) $display("FAIL b2b_no_write_unpaused: got %0d want %0d", n_writes, w0); else n_pass++;
        paused = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (hs_bus.hs_write === 1'b1) found = 1'b1;
        end
        n_checks++; if (found !== 1'b1) $display("FAIL b2b_write_seen: got %b want 1", found); else n_pass++;
        n_checks++; if (hs_bus.hs_address !== BASE + 11'h010 || hs_bus.hs_data_in !== 8'h11)
            $display("FAIL b2b_first: got %h/%h want %h/11", hs_bus.hs_address, hs_bus.hs_data_in, BASE + 11'h010); else n_pass++;
        tick();
        n_checks++; if (hs_bus.hs_write !== 1'b1 || hs_bus.hs_address !== BASE + 11'h020 || hs_bus.hs_data_in !== 8'h22)
            $display("FAIL b2b_second: got w=%b %h/%h want w=1 %h/22", hs_bus.hs_write, hs_bus.hs_address, hs_bus.hs_data_in, BASE + 11'h020); else n_pass++;
        tick();
        n_checks++; if (hs_bus.hs_write !== 1'b0) $display("FAIL b2b_end: got %b want 0", hs_bus.hs_write); else n_pass++;
        repeat (5) tick();
        n_checks++; if (n_writes !== w0 + 2) $display("FAIL b2b_write_count: got %0d want %0d", n_writes, w0 + 2); else n_pass++;
        n_checks++; if (dl_busy !== 1'b0 || pause_req !== 1'b0) $display("FAIL b2b_drained: got busy=%b preq=%b want 0/0", dl_busy, pause_req); else n_pass++;
        paused = 1'b0;
        tick();
    endtask

    // Runs one dump; expected bytes come from the fill pattern, with the
    // trailing checksum byte derived from the bench's own expected stream.
    task automatic run_dump(input bit ones, input bit do_drop, input int exp_bytes,
                            output logic [7:0] last_byte);
        int         nbytes = 0;
        int         ndone  = 0;
        int         post   = 0;
        int         phase  = 0;
        int         pc     = 0;
        bit         fin    = 1'b0;
        bit         prev_stall = 1'b0;
        logic [7:0] prev_data = 8'd0;
        logic [7:0] exp_b;
        logic [7:0] sum = 8'd0;
        last_byte = 8'd0;
        fill_mem(ones);
        paused = 1'b1;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        for (int cyc = 0; cyc < 8000 && !fin; cyc++) begin
            if (prev_stall) begin
                n_checks++;
                if (ul_valid !== 1'b1 || ul_data !== prev_data)
                    $display("FAIL dump_stall_hold: got v=%b d=%h want v=1 d=%h", ul_valid, ul_data, prev_data);
                else n_pass++;
            end
            if (ul_done === 1'b1) ndone++;
            if (ndone > 0) post++;
            if (post > 4) fin = 1'b1;
            if (do_drop) begin
                case (phase)
                    0: if (hs_bus.hs_access === 1'b1 && hs_bus.hs_address === BASE + 11'd10) begin
                           paused = 1'b0; phase = 1; pc = 0;
                       end
                    1: begin
                           pc++;
                           if (pc == 1) begin
                               n_checks++; if (hs_bus.hs_access !== 1'b0) $display("FAIL drop_access_fall: got %b want 0", hs_bus.hs_access); else n_pass++;
                           end
                           if (pc == 4) begin paused = 1'b1; phase = 2; end
                       end
                    2: if (hs_bus.hs_access === 1'b1) begin
                           n_checks++; if (hs_bus.hs_address !== BASE + 11'd10) $display("FAIL drop_reread_addr: got %h want %h", hs_bus.hs_address, BASE + 11'd10); else n_pass++;
                           phase = 3;
                       end
                    default: ;
                endcase
            end
            ul_ready = 1'($urandom_range(0, 1));
            if (ul_valid === 1'b1 && ul_ready) begin
                if (nbytes < HS_LEN) exp_b = ones ? 8'h01 : (8'(nbytes) ^ 8'h5A);
                else                 exp_b = ~sum + 8'd1;
                n_checks++;
                if (ul_data !== exp_b) $display("FAIL dump_byte[%0d]: got %h want %h", nbytes, ul_data, exp_b);
                else n_pass++;
                sum = sum + exp_b;
                last_byte = ul_data;
                nbytes++;
            end
            prev_stall = (ul_valid === 1'b1) && !ul_ready;
            prev_data  = ul_data;
            tick();
        end
        ul_ready = 1'b0;
        n_checks++; if (fin !== 1'b1) $display("FAIL dump_timeout: got done=%0d want completion", ndone); else n_pass++;
        n_checks++; if (nbytes !== exp_bytes) $display("FAIL dump_byte_count: got %0d want %0d", nbytes, exp_bytes); else n_pass++;
        n_checks++; if (ndone !== 1) $display("FAIL dump_done_pulses: got %0d want 1", ndone); else n_pass++;
        n_checks++; if (pause_req !== 1'b0 || ul_valid !== 1'b0) $display("FAIL dump_idle_after: got preq=%b v=%b want 0/0", pause_req, ul_valid); else n_pass++;
        if (do_drop) begin
            n_checks++; if (phase !== 3) $display("FAIL drop_sequence: got phase %0d want 3", phase); else n_pass++;
        end
    endtask

`ifdef HS_CHECKSUM_EN
    localparam int EXP_BYTES = HS_LEN + 1;
`else
    localparam int EXP_BYTES = HS_LEN;
`endif

    task automatic test_dump();
        logic [7:0] lb;
        run_dump(1'b0, 1'b0, EXP_BYTES, lb);
    endtask

    task automatic test_pause_drop();
        logic [7:0] lb;
        run_dump(1'b0, 1'b1, EXP_BYTES, lb);
    endtask

    task automatic test_checksum();
        logic [7:0] lb;
        run_dump(1'b1, 1'b0, EXP_BYTES, lb);
`ifdef HS_CHECKSUM_EN
        n_checks++; if (lb !== 8'h80) $display("FAIL cksum_byte: got %h want 80", lb); else n_pass++;
`else
        n_checks++; if (lb !== 8'h01) $display("FAIL plain_last_byte: got %h want 01", lb); else n_pass++;
`endif
    endtask

    task automatic test_async_reset();
        bit seen = 1'b0;
        fill_mem(1'b0);
        paused = 1'b1;
        ul_ready = 1'b0;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            tick();
            if (ul_valid === 1'b1) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b1) $display("FAIL arst_valid_seen: got %b want 1", seen); else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (ul_valid !== 1'b0 || ul_data !== 8'h00) $display("FAIL arst_ul_clear: got v=%b d=%h want 0/00", ul_valid, ul_data); else n_pass++;
        n_checks++; if (pause_req !== 1'b0 || hs_bus.hs_access !== 1'b0) $display("FAIL arst_core_clear: got preq=%b acc=%b want 0/0", pause_req, hs_bus.hs_access); else n_pass++;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        n_checks++; if (ul_valid !== 1'b0 || ul_done !== 1'b0 || pause_req !== 1'b0) $display("FAIL arst_no_resume: got v=%b done=%b preq=%b want 0/0/0", ul_valid, ul_done, pause_req); else n_pass++;
        paused = 1'b0;
    endtask

    task automatic test_protocol();
        n_checks++; if (n_bad_write !== 0) $display("FAIL write_without_access: got %0d want 0", n_bad_write); else n_pass++;
    endtask

    initial begin
        fill_mem(1'b0);
        test_reset();
        test_single_write();
        test_back_to_back();
        test_dump();
        test_pause_drop();
        test_checksum();
        test_async_reset();
        test_protocol();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
